// File: rtl/addsub_slice_seq.sv
// Multi-cycle W-bit add/subtract sequencer: one SLICE-bit ripple slice per cycle, LSB first.
// Optional saturation on signed overflow is enabled by defining ADDSUB_SAT_EN.
module addsub_slice_seq #(
  parameter int SLICE  = 4,
  parameter int NSLICE = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [SLICE*NSLICE-1:0]   in_a_i,
  input  logic [SLICE*NSLICE-1:0]   in_b_i,
  input  logic                      in_sub_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [SLICE*NSLICE-1:0]   out_s_o,
  output logic                      out_cout_o,
  output logic                      out_ovf_o,
  output logic                      out_zero_o
);
  localparam int W  = SLICE * NSLICE;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d, out_s_q, out_s_d, fin_s;
  logic            sub_q, sub_d, carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic            cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [SLICE+1:0] slice_s;

  // Returns {carry_out, carry_into_msb, sum[SLICE-1:0]} for one add/sub slice.
  function automatic logic [SLICE+1:0] slice_add(input logic [SLICE-1:0] a,
                                                 input logic [SLICE-1:0] b,
                                                 input logic sub,
                                                 input logic cin);
    logic [SLICE-1:0] bx;
    logic [SLICE-1:0] lo;
    logic [1:0]       hi;
    bx = b ^ {SLICE{sub}};
    lo = {1'b0, a[SLICE-2:0]} + {1'b0, bx[SLICE-2:0]} + {{(SLICE-1){1'b0}}, cin};
    hi = {1'b0, a[SLICE-1]} + {1'b0, bx[SLICE-1]} + {1'b0, lo[SLICE-1]};
    return {hi[1], lo[SLICE-1], hi[0], lo[SLICE-2:0]};
  endfunction

  assign slice_s = slice_add(a_q[idx_q*SLICE +: SLICE], b_q[idx_q*SLICE +: SLICE], sub_q, carry_q);

  // Next-state and datapath control for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    res_d       = res_q;
    out_s_d     = out_s_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    fin_s       = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d        = in_a_i;
          b_d        = in_b_i;
          sub_d      = in_sub_i;
          carry_d    = in_sub_i;
          idx_d      = {IW{1'b0}};
          in_ready_d = 1'b0;
          state_d    = RUN;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      RUN: begin
        res_d[idx_q*SLICE +: SLICE] = slice_s[SLICE-1:0];
        carry_d = slice_s[SLICE+1];
        idx_d   = idx_q + IW'(1);
        fin_s   = res_d;
        if (idx_q == IW'(NSLICE - 1)) begin
          cout_d = slice_s[SLICE+1];
          ovf_d  = slice_s[SLICE+1] ^ slice_s[SLICE];
`ifdef ADDSUB_SAT_EN
          // Overflow direction follows operand A's sign for both add and subtract.
          if (ovf_d) begin
            fin_s = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
          end else begin
            fin_s = res_d;
          end
`endif
          out_s_d     = fin_s;
          zero_d      = (fin_s == {W{1'b0}});
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= {IW{1'b0}};
      res_q       <= {W{1'b0}};
      out_s_q     <= {W{1'b0}};
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      res_q       <= res_d;
      out_s_q     <= out_s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_s_o     = out_s_q;
  assign out_cout_o  = cout_q;
  assign out_ovf_o   = ovf_q;
  assign out_zero_o  = zero_q;
endmodule

// File: tb/tb_addsub_slice_seq.sv
// Self-checking bench for addsub_slice_seq: directed cases plus random operations
// against an integer-arithmetic reference model (honours ADDSUB_SAT_EN).
module tb_addsub_slice_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = 16'h0000;
  logic [15:0] in_b = 16'h0000;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_s;
  logic        out_cout, out_ovf, out_zero;

  int n_vec = 0;
  int n_err = 0;

  addsub_slice_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b), .in_sub_i(in_sub),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_s_o(out_s), .out_cout_o(out_cout), .out_ovf_o(out_ovf), .out_zero_o(out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input bit sub,
                       output logic [15:0] s, output bit cout, output bit ovf, output bit zero);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    ur = sub ? (ua - ub) : (ua + ub);
    sr = sub ? (sa - sb) : (sa + sb);
    s    = ur[15:0];
    cout = sub ? (ua >= ub) : (ur > 65535);
    ovf  = (sr > 32767) || (sr < -32768);
`ifdef ADDSUB_SAT_EN
    if (ovf) s = (sr > 0) ? 16'h7FFF : 16'h8000;
`endif
    zero = (s == 16'h0000);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit sub, input int stall);
    logic [15:0] es;
    bit ec, eo, ez;
    int cnt;
    model(a, b, sub, es, ec, eo, ez);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom); in_sub = 1'($urandom);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      chk("in_ready_run", in_ready, 0);
      @(negedge clk);
      cnt++;
    end
    chk("latency", cnt, 4);
    chk("out_s", out_s, es);
    chk("out_cout", out_cout, ec);
    chk("out_ovf", out_ovf, eo);
    chk("out_zero", out_zero, ez);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom);
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_ready", in_ready, 0);
      chk("stall_s", out_s, es);
      chk("stall_flags", {out_cout, out_ovf, out_zero}, {ec, eo, ez});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_valid", out_valid, 0);
    chk("drain_ready", in_ready, 1);
    chk("hold_s", out_s, es);
  endtask

  initial begin
    logic [15:0] prev_s;
    bit pc, po, pz;
    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_outs", {out_s, out_cout, out_ovf, out_zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0FCD, 1'b0, 0);
    run_op(16'h0005, 16'h0007, 1'b1, 0);
    run_op(16'h1234, 16'h1234, 1'b1, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'h0001, 1'b1, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 3);
    run_op(16'h8000, 16'h8000, 1'b0, 1);
    run_op(16'h7FFF, 16'hFFFF, 1'b1, 2);

    // Abort mid-operation with slice index 2 in flight.
    model(16'h7FFF, 16'hFFFF, 1'b1, prev_s, pc, po, pz);
    @(negedge clk);
    in_valid = 1'b1; in_a = 16'hABCD; in_b = 16'h1111; in_sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_abort_s", out_s, prev_s);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", in_ready, 1);
    chk("abort_valid", out_valid, 0);
    chk("abort_outs", {out_s, out_cout, out_ovf, out_zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_valid", out_valid, 0);
    end

    for (int i = 0; i < 40; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
